vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
Parametrised successor vending controller with NUM_PROD products, a price table set by parameter, and per-product stock counters that support restock. Coins accumulate across several insertions into a saturating credit register. Payment can also be made online. An inactivity timeout refunds credit automatically. The block sits between the front-panel/payment input logic and the dispenser/change-hopper drivers.

Parameters:
NUM_PROD, 5, number of products; prod_code values 0..NUM_PROD-1 are valid.
CODE_W, 3, width of prod_code and restock_code; must satisfy 2^CODE_W >= NUM_PROD.
PRICE_W, 7, width of prices and coin_val.
CREDIT_W, 8, width of the credit accumulator and return_change; must be >= PRICE_W.
STOCK_W, 4, width of each per-product stock counter.
INIT_STOCK, 4, stock value of every product after reset.
PRICES, {20,20,35,50,10}, packed NUM_PROD*PRICE_W vector; entry i (bits i*PRICE_W +: PRICE_W) is the price of product i. Default gives 0:10, 1:50, 2:35, 3:20, 4:20.
TIMEOUT_CYC, 16, number of cycles in PAY without a coin before an automatic refund; must be >= 1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous reset, active-low.
start  in  1  begin a transaction; sampled in IDLE.
cancel  in  1  abort; sampled in SELECT and PAY.
sel_valid  in  1  prod_code is valid this cycle.
prod_code  in  CODE_W  product selection.
coin_valid  in  1  single-cycle pulse: coin_val is inserted this cycle.
coin_val  in  PRICE_W  value of the inserted coin.
online_payment  in  1  online payment confirmed for the selected product.
restock_valid  in  1  restock request; accepted in every state.
restock_code  in  CODE_W  product to restock.
restock_qty  in  STOCK_W  quantity to add.
state  out  3  current FSM state.
dispense_prod  out  1  one-cycle pulse; dispense prod_id.
prod_id  out  CODE_W  product being dispensed; valid while dispense_prod=1, otherwise 0.
prod_price  out  PRICE_W  latched price; valid in PAY and DISPENSE, otherwise 0.
credit  out  CREDIT_W  current accumulated credit.
change_valid  out  1  one-cycle pulse; return_change is valid.
return_change  out  CREDIT_W  change or refund amount; 0 when change_valid=0.
sold_out  out  1  one-cycle pulse; the selected product has stock 0.
sel_error  out  1  one-cycle pulse; prod_code >= NUM_PROD.
stock_flat  out  NUM_PROD*STOCK_W  all stock counters, packed as product i at i*STOCK_W.

Behaviour:
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- Reset (rst_n=0, asynchronous): state=IDLE, credit=0, latched price and product=0, every pulse output=0, timeout counter=0, every stock counter=INIT_STOCK. Reset asserted mid-transaction discards credit with no refund pulse.
- State encoding: IDLE=0, SELECT=1, PAY=2, DISPENSE=3, REFUND=4. Any other encoding goes to IDLE with credit cleared.
- IDLE: start=1 -> SELECT. credit is held at 0.
- SELECT (higher entries take priority):
  - cancel -> IDLE.
  - sel_valid with prod_code >= NUM_PROD -> pulse sel_error, go to IDLE.
  - sel_valid with stock[prod_code]=0 -> pulse sold_out, go to IDLE.
  - sel_valid otherwise -> latch prod_code and PRICES[prod_code], clear the timeout counter, go to PAY.
  - no sel_valid -> stay in SELECT (no timeout in SELECT).
- PAY: let sum = credit + coin_val if coin_valid=1, else credit. sum saturates at 2^CREDIT_W-1. Priority, highest first:
  1. cancel -> REFUND. Refund amount = credit; a coin arriving in the same cycle is included, so refund = sum.
  2. online_payment -> DISPENSE, change = sum (every inserted coin is returned).
  3. sum >= price -> DISPENSE, change = sum - price.
  4. coin_valid (sum still below price) -> credit = sum, timeout counter cleared, stay in PAY.
  5. timeout counter = TIMEOUT_CYC-1 -> REFUND, refund = credit; otherwise increment the counter and stay in PAY.
- DISPENSE (one cycle):
  - dispense_prod=1, prod_id=latched product, change_valid=1, return_change=computed change (change_valid is asserted even when change=0).
  - stock[prod_id] decrements by 1.
  - credit clears at exit; next state is IDLE.
- REFUND (one cycle): change_valid=1, return_change=refund amount, dispense_prod=0; credit clears; next state is IDLE.
- Inputs that are not listed for a state are ignored in that state, including coins outside PAY.
- Restock:
  - stock[restock_code] += restock_qty, saturating at 2^STOCK_W-1.
  - restock_code >= NUM_PROD is ignored.
  - If the restock and a DISPENSE decrement hit the same product in the same cycle, the net result is old + qty - 1, saturating.
  - A restock landing in the same cycle as a SELECT stock check does not affect that check; the pre-update value is used.
- Latency: the selection is accepted 1 cycle after sel_valid is sampled. dispense_prod and change_valid assert in the cycle after the paying event. The machine is back in IDLE 1 cycle after that.

Test Plan:
- start; select code 2 (price 35); coins 20, 10, 10 on separate cycles -> DISPENSE, prod_id=2, return_change=5, stock[2] goes 4->3, then IDLE.
- Select code 1 (price 50); coin 20; cancel asserted together with coin 10 -> REFUND, return_change=30, dispense_prod=0, stock unchanged.
- Select code 0; coin 5; online_payment -> dispense_prod=1, return_change=5. Separately, select code 4 with no coins; wait 16 cycles -> REFUND with return_change=0.
- Dispense product 3 four times -> stock[3]=0; the fifth selection of 3 pulses sold_out and returns to IDLE. Then restock_qty=15 while stock=3 -> stock saturates at 15.
- Select code 6 -> sel_error pulse, return to IDLE. Drop rst_n in PAY with credit=30 -> immediately IDLE, credit=0, stocks=INIT_STOCK, no change_valid pulse.
- Restock product 2 by 2 in the same cycle as a DISPENSE of product 2 at stock 4 -> stock[2]=5.

Source files
------------

// File: rtl/vending_machine_param.sv
// ---------------------------------------------------------------------------
// vending_machine_param
//
// Parametrised vending controller. It sits between the front-panel/payment
// input logic and the dispenser/change-hopper drivers. It has NUM_PROD
// products, a price table fixed by parameter, and per-product stock counters
// that can be restocked. Coins add into a saturating credit register, and
// payment can also be confirmed online. If no coin arrives for a while, the
// credit is refunded automatically.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               begin a transaction (IDLE)
//   cancel              abort (SELECT, PAY)
//   sel_valid/prod_code product selection (SELECT)
//   coin_valid/coin_val single-cycle coin insertion (PAY)
//   online_payment      online payment confirmed (PAY)
//   restock_valid/code/qty  add stock to one product (any state)
//   state               current FSM state
//   dispense_prod/prod_id   dispense pulse and product index
//   prod_price          latched price (PAY and DISPENSE, otherwise 0)
//   credit              accumulated credit
//   change_valid/return_change  change or refund pulse and amount
//   sold_out, sel_error one-cycle selection failure pulses
//   stock_flat          all stock counters, product i at i*STOCK_W
//
// Every output comes either from a register or from a decode of registers.
// No input reaches an output combinationally.
// ---------------------------------------------------------------------------
module vending_machine_param #(
   parameter int NUM_PROD    = 5,
   parameter int CODE_W      = 3,
   parameter int PRICE_W     = 7,
   parameter int CREDIT_W    = 8,
   parameter int STOCK_W     = 4,
   parameter int INIT_STOCK  = 4,
   parameter logic [NUM_PROD*PRICE_W-1:0] PRICES =
      {7'd20, 7'd20, 7'd35, 7'd50, 7'd10},
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          cancel,
   input  logic                          sel_valid,
   input  logic [CODE_W-1:0]             prod_code,
   input  logic                          coin_valid,
   input  logic [PRICE_W-1:0]            coin_val,
   input  logic                          online_payment,
   input  logic                          restock_valid,
   input  logic [CODE_W-1:0]             restock_code,
   input  logic [STOCK_W-1:0]            restock_qty,
   output logic [2:0]                    state,
   output logic                          dispense_prod,
   output logic [CODE_W-1:0]             prod_id,
   output logic [PRICE_W-1:0]            prod_price,
   output logic [CREDIT_W-1:0]           credit,
   output logic                          change_valid,
   output logic [CREDIT_W-1:0]           return_change,
   output logic                          sold_out,
   output logic                          sel_error,
   output logic [NUM_PROD*STOCK_W-1:0]   stock_flat
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SELECT   = 3'd1;
   localparam logic [2:0] ST_PAY      = 3'd2;
   localparam logic [2:0] ST_DISPENSE = 3'd3;
   localparam logic [2:0] ST_REFUND   = 3'd4;

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
   localparam logic [STOCK_W-1:0]  STOCK_MAX  = {STOCK_W{1'b1}};
   localparam logic [STOCK_W-1:0]  STOCK_INIT = STOCK_W'(INIT_STOCK);

   // Looks up the price of a product code in the packed price table.
   function automatic logic [PRICE_W-1:0] price_of(input logic [CODE_W-1:0] code);
      logic [PRICE_W-1:0] p;
      p = {PRICE_W{1'b0}};
      for (int i = 0; i < NUM_PROD; i++) begin
         p = (code == CODE_W'(i)) ? PRICES[i*PRICE_W +: PRICE_W] : p;
      end
      return p;
   endfunction

   // Adds a coin to the credit and clamps the result at the all-ones value.
   function automatic logic [CREDIT_W-1:0] credit_add(input logic [CREDIT_W-1:0] a,
                                                      input logic [PRICE_W-1:0]  b);
      logic [CREDIT_W:0] s;
      s = {1'b0, a} + (CREDIT_W+1)'(b);
      return s[CREDIT_W] ? CREDIT_MAX : s[CREDIT_W-1:0];
   endfunction

   // Computes the next stock value. The restock and the dispense decrement are
   // combined first, and only the net result is saturated, so that
   // max + qty - 1 still clamps to max.
   function automatic logic [STOCK_W-1:0] stock_next(input logic [STOCK_W-1:0] old,
                                                     input logic [STOCK_W-1:0] qty,
                                                     input logic               inc,
                                                     input logic               dec);
      logic [STOCK_W:0] t;
      t = {1'b0, old} + (inc ? {1'b0, qty} : {(STOCK_W+1){1'b0}});
      t = (dec && (t != {(STOCK_W+1){1'b0}})) ? (t - (STOCK_W+1)'(1)) : t;
      return t[STOCK_W] ? STOCK_MAX : t[STOCK_W-1:0];
   endfunction

   logic [2:0]          state_r, state_nxt_s;
   logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
   logic [CREDIT_W-1:0] change_r, change_nxt_s;
   logic [TMR_W-1:0]    timer_r, timer_nxt_s;
   logic [CODE_W-1:0]   prod_r, prod_nxt_s;
   logic [PRICE_W-1:0]  price_r, price_nxt_s;
   logic                sold_out_r, sold_out_nxt_s;
   logic                sel_error_r, sel_error_nxt_s;
   logic [STOCK_W-1:0]  stock_r     [NUM_PROD];
   logic [STOCK_W-1:0]  stock_nxt_s [NUM_PROD];

   logic [CREDIT_W-1:0] sum_s;
   logic [CREDIT_W-1:0] price_ext_s;
   logic [STOCK_W-1:0]  sel_stock_s;
   logic                code_ok_s;

   // Builds the PAY-state credit sum, the widened price, and the selection
   // checks. The stock check reads the registered value, so a restock in the
   // same cycle does not change the result.
   always_comb begin
      sum_s       = credit_add(credit_r, coin_valid ? coin_val : {PRICE_W{1'b0}});
      price_ext_s = CREDIT_W'(price_r);
      code_ok_s   = (int'(prod_code) < NUM_PROD);
      sel_stock_s = {STOCK_W{1'b0}};
      for (int i = 0; i < NUM_PROD; i++) begin
         sel_stock_s = (prod_code == CODE_W'(i)) ? stock_r[i] : sel_stock_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and next values of the transaction datapath.
   always_comb begin
      state_nxt_s     = state_r;
      credit_nxt_s    = credit_r;
      change_nxt_s    = change_r;
      timer_nxt_s     = timer_r;
      prod_nxt_s      = prod_r;
      price_nxt_s     = price_r;
      sold_out_nxt_s  = 1'b0;
      sel_error_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            credit_nxt_s = {CREDIT_W{1'b0}};
            if (start) begin
               state_nxt_s = ST_SELECT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SELECT: begin
            if (cancel) begin
               state_nxt_s = ST_IDLE;
            end else if (sel_valid) begin
               if (!code_ok_s) begin
                  sel_error_nxt_s = 1'b1;
                  state_nxt_s     = ST_IDLE;
               end else if (sel_stock_s == {STOCK_W{1'b0}}) begin
                  sold_out_nxt_s = 1'b1;
                  state_nxt_s    = ST_IDLE;
               end else begin
                  prod_nxt_s  = prod_code;
                  price_nxt_s = price_of(prod_code);
                  timer_nxt_s = {TMR_W{1'b0}};
                  state_nxt_s = ST_PAY;
               end
            end else begin
               state_nxt_s = ST_SELECT;
            end
         end
         ST_PAY: begin
            // On exit, credit keeps the full paid amount until DISPENSE/REFUND ends.
            if (cancel) begin
               change_nxt_s = sum_s;
               credit_nxt_s = sum_s;
               state_nxt_s  = ST_REFUND;
            end else if (online_payment) begin
               change_nxt_s = sum_s;
               credit_nxt_s = sum_s;
               state_nxt_s  = ST_DISPENSE;
            end else if (sum_s >= price_ext_s) begin
               change_nxt_s = sum_s - price_ext_s;
               credit_nxt_s = sum_s;
               state_nxt_s  = ST_DISPENSE;
            end else if (coin_valid) begin
               credit_nxt_s = sum_s;
               timer_nxt_s  = {TMR_W{1'b0}};
               state_nxt_s  = ST_PAY;
            end else if (timer_r == TMR_LAST) begin
               change_nxt_s = credit_r;
               state_nxt_s  = ST_REFUND;
            end else begin
               timer_nxt_s = timer_r + TMR_W'(1);
               state_nxt_s = ST_PAY;
            end
         end
         ST_DISPENSE, ST_REFUND: begin
            credit_nxt_s = {CREDIT_W{1'b0}};
            prod_nxt_s   = {CODE_W{1'b0}};
            price_nxt_s  = {PRICE_W{1'b0}};
            state_nxt_s  = ST_IDLE;
         end
         default: begin
            credit_nxt_s = {CREDIT_W{1'b0}};
            prod_nxt_s   = {CODE_W{1'b0}};
            price_nxt_s  = {PRICE_W{1'b0}};
            timer_nxt_s  = {TMR_W{1'b0}};
            state_nxt_s  = ST_IDLE;
         end
      endcase
   end

   // Transaction datapath registers: credit, change, timeout counter, latched
   // product/price and the selection-failure pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_r    <= {CREDIT_W{1'b0}};
         change_r    <= {CREDIT_W{1'b0}};
         timer_r     <= {TMR_W{1'b0}};
         prod_r      <= {CODE_W{1'b0}};
         price_r     <= {PRICE_W{1'b0}};
         sold_out_r  <= 1'b0;
         sel_error_r <= 1'b0;
      end else begin
         credit_r    <= credit_nxt_s;
         change_r    <= change_nxt_s;
         timer_r     <= timer_nxt_s;
         prod_r      <= prod_nxt_s;
         price_r     <= price_nxt_s;
         sold_out_r  <= sold_out_nxt_s;
         sel_error_r <= sel_error_nxt_s;
      end
   end

   // Next stock per product. An out-of-range restock_code matches no product,
   // so it has no effect.
   always_comb begin
      for (int i = 0; i < NUM_PROD; i++) begin
         stock_nxt_s[i] = stock_next(stock_r[i], restock_qty,
                                     restock_valid && (restock_code == CODE_W'(i)),
                                     (state_r == ST_DISPENSE) && (prod_r == CODE_W'(i)));
      end
   end

   // Per-product stock counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PROD; i++) begin
            stock_r[i] <= STOCK_INIT;
         end
      end else begin
         for (int i = 0; i < NUM_PROD; i++) begin
            stock_r[i] <= stock_nxt_s[i];
         end
      end
   end

   // Output decode from the state and datapath registers.
   always_comb begin
      state     = state_r;
      credit    = credit_r;
      sold_out  = sold_out_r;
      sel_error = sel_error_r;
      if (state_r == ST_DISPENSE) begin
         dispense_prod = 1'b1;
         prod_id       = prod_r;
      end else begin
         dispense_prod = 1'b0;
         prod_id       = {CODE_W{1'b0}};
      end
      if ((state_r == ST_PAY) || (state_r == ST_DISPENSE)) begin
         prod_price = price_r;
      end else begin
         prod_price = {PRICE_W{1'b0}};
      end
      if ((state_r == ST_DISPENSE) || (state_r == ST_REFUND)) begin
         change_valid  = 1'b1;
         return_change = change_r;
      end else begin
         change_valid  = 1'b0;
         return_change = {CREDIT_W{1'b0}};
      end
      for (int i = 0; i < NUM_PROD; i++) begin
         stock_flat[i*STOCK_W +: STOCK_W] = stock_r[i];
      end
   end

endmodule

// File: tb/tb_vending_machine_param.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_param
//
// Table-driven bench for vending_machine_param with default parameters.
// Each applied vector pushes its expected post-edge outputs onto a scoreboard
// queue. The entry is popped and compared one time unit after the clock edge.
// Hand-written sequences cover the timeout, sold-out, reset and
// restock-collision cases.
// ---------------------------------------------------------------------------
module tb_vending_machine_param;
   localparam int NP = 5;
   localparam int CW = 3;
   localparam int PW = 7;
   localparam int KW = 8;
   localparam int SW = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start, cancel, sel_valid, coin_valid, online_payment, restock_valid;
   logic [CW-1:0]      prod_code, restock_code;
   logic [PW-1:0]      coin_val;
   logic [SW-1:0]      restock_qty;
   logic [2:0]         state;
   logic               dispense_prod, change_valid, sold_out, sel_error;
   logic [CW-1:0]      prod_id;
   logic [PW-1:0]      prod_price;
   logic [KW-1:0]      credit, return_change;
   logic [NP*SW-1:0]   stock_flat;

   vending_machine_param dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
      .sel_valid(sel_valid), .prod_code(prod_code), .coin_valid(coin_valid),
      .coin_val(coin_val), .online_payment(online_payment),
      .restock_valid(restock_valid), .restock_code(restock_code),
      .restock_qty(restock_qty), .state(state), .dispense_prod(dispense_prod),
      .prod_id(prod_id), .prod_price(prod_price), .credit(credit),
      .change_valid(change_valid), .return_change(return_change),
      .sold_out(sold_out), .sel_error(sel_error), .stock_flat(stock_flat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          start, cancel, sel_valid;
      logic [CW-1:0] code;
      logic          coin_valid;
      logic [PW-1:0] coin;
      logic          online;
      logic          rs_valid;
      logic [CW-1:0] rs_code;
      logic [SW-1:0] rs_qty;
   } in_t;

   typedef struct {
      string tag;
      int st, disp, pid, price, credit, cv, chg, so, se, sidx, sval;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic in_t inp(int st, int cn, int sv, int code, int cvld, int coin, int onl);
      in_t r;
      r.start      = (st != 0);
      r.cancel     = (cn != 0);
      r.sel_valid  = (sv != 0);
      r.code       = CW'(code);
      r.coin_valid = (cvld != 0);
      r.coin       = PW'(coin);
      r.online     = (onl != 0);
      r.rs_valid   = 1'b0;
      r.rs_code    = '0;
      r.rs_qty     = '0;
      return r;
   endfunction

   function automatic in_t idle();
      return inp(0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic in_t rs(in_t r, int code, int qty);
      in_t o;
      o = r;
      o.rs_valid = 1'b1;
      o.rs_code  = CW'(code);
      o.rs_qty   = SW'(qty);
      return o;
   endfunction

   // credit < 0 means "not checked"; sidx < 0 means "no stock check".
   function automatic exp_t ex(string tag, int st, int disp, int pid, int price, int cr,
                               int cv, int chg, int so = 0, int se = 0,
                               int sidx = -1, int sval = 0);
      exp_t e;
      e.tag = tag; e.st = st; e.disp = disp; e.pid = pid; e.price = price;
      e.credit = cr; e.cv = cv; e.chg = chg; e.so = so; e.se = se;
      e.sidx = sidx; e.sval = sval;
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({e.tag, "/state"},         32'(state),         e.st);
         check({e.tag, "/dispense_prod"}, 32'(dispense_prod), e.disp);
         check({e.tag, "/prod_id"},       32'(prod_id),       e.pid);
         check({e.tag, "/prod_price"},    32'(prod_price),    e.price);
         check({e.tag, "/change_valid"},  32'(change_valid),  e.cv);
         check({e.tag, "/return_change"}, 32'(return_change), e.chg);
         check({e.tag, "/sold_out"},      32'(sold_out),      e.so);
         check({e.tag, "/sel_error"},     32'(sel_error),     e.se);
         if (e.credit >= 0) check({e.tag, "/credit"}, 32'(credit), e.credit);
         if (e.sidx >= 0) check({e.tag, "/stock"}, 32'(stock_flat[e.sidx*SW +: SW]), e.sval);
      end
   endtask

   task automatic drive(in_t i);
      start          = i.start;
      cancel         = i.cancel;
      sel_valid      = i.sel_valid;
      prod_code      = i.code;
      coin_valid     = i.coin_valid;
      coin_val       = i.coin;
      online_payment = i.online;
      restock_valid  = i.rs_valid;
      restock_code   = i.rs_code;
      restock_qty    = i.rs_qty;
   endtask

   task automatic apply(in_t i, exp_t e);
      @(negedge clk);
      drive(i);
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      drive(idle());
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/state",      32'(state),        32'd0);
      check("reset/credit",     32'(credit),       32'd0);
      check("reset/stock_flat", 32'(stock_flat),   32'h44444);
      check("reset/change",     32'(change_valid), 32'd0);
      check("reset/price",      32'(prod_price),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Coins 20+10+10 for product 2 (price 35); change is 5.
      tbl.push_back('{inp(1,0,0,0,0,0,0),  ex("t1start", 1,0,0,0,0,0,0)});
      tbl.push_back('{inp(0,0,1,2,0,0,0),  ex("t1sel",   2,0,0,35,0,0,0)});
      tbl.push_back('{inp(0,0,0,0,1,20,0), ex("t1c20",   2,0,0,35,20,0,0)});
      tbl.push_back('{inp(0,0,0,0,1,10,0), ex("t1c10",   2,0,0,35,30,0,0)});
      tbl.push_back('{inp(0,0,0,0,1,10,0), ex("t1pay",   3,1,2,35,-1,1,5,0,0,2,4)});
      tbl.push_back('{idle(),              ex("t1done",  0,0,0,0,0,0,0,0,0,2,3)});
      // Product 1: coin 20, then cancel together with coin 10; refund is 30.
      tbl.push_back('{inp(1,0,0,0,0,0,0),  ex("t2start", 1,0,0,0,0,0,0)});
      tbl.push_back('{inp(0,0,1,1,0,0,0),  ex("t2sel",   2,0,0,50,0,0,0)});
      tbl.push_back('{inp(0,0,0,0,1,20,0), ex("t2c20",   2,0,0,50,20,0,0)});
      tbl.push_back('{inp(0,1,0,0,1,10,0), ex("t2refund",4,0,0,0,-1,1,30)});
      tbl.push_back('{idle(),              ex("t2done",  0,0,0,0,0,0,0,0,0,1,4)});
      // Product 0: coin 5, then online payment; all 5 is returned.
      tbl.push_back('{inp(1,0,0,0,0,0,0),  ex("t3start", 1,0,0,0,0,0,0)});
      tbl.push_back('{inp(0,0,1,0,0,0,0),  ex("t3sel",   2,0,0,10,0,0,0)});
      tbl.push_back('{inp(0,0,0,0,1,5,0),  ex("t3c5",    2,0,0,10,5,0,0)});
      tbl.push_back('{inp(0,0,0,0,0,0,1),  ex("t3online",3,1,0,10,-1,1,5,0,0,0,4)});
      tbl.push_back('{idle(),              ex("t3done",  0,0,0,0,0,0,0,0,0,0,3)});
      // A coin in IDLE is ignored; an out-of-range code gives sel_error.
      tbl.push_back('{inp(0,0,0,0,1,25,0), ex("idlecoin",0,0,0,0,0,0,0)});
      tbl.push_back('{inp(1,0,0,0,0,0,0),  ex("t5start", 1,0,0,0,0,0,0)});
      tbl.push_back('{inp(0,0,1,6,0,0,0),  ex("t5selerr",0,0,0,0,0,0,0,0,1)});
      // SELECT waits without timing out, ignores coins, and honours cancel.
      tbl.push_back('{inp(1,0,0,0,0,0,0),  ex("s_start", 1,0,0,0,0,0,0)});
      tbl.push_back('{inp(0,0,0,0,1,30,0), ex("s_wait",  1,0,0,0,0,0,0)});
      tbl.push_back('{inp(0,1,0,0,0,0,0),  ex("s_cancel",0,0,0,0,0,0,0)});

      foreach (tbl[k]) apply(tbl[k].i, tbl[k].e);

      // Timeout: product 4, no coins; the refund comes on the 16th PAY cycle.
      apply(inp(1,0,0,0,0,0,0), ex("to_start", 1,0,0,0,0,0,0));
      apply(inp(0,0,1,4,0,0,0), ex("to_sel",   2,0,0,20,0,0,0));
      for (int k = 0; k < 15; k++) apply(idle(), ex("to_wait", 2,0,0,20,0,0,0));
      apply(idle(), ex("to_refund", 4,0,0,0,0,1,0));
      apply(idle(), ex("to_done",   0,0,0,0,0,0,0,0,0,4,4));

      // Sell out product 3 with exact coins, then check the sold_out pulse.
      for (int k = 0; k < 4; k++) begin
         apply(inp(1,0,0,0,0,0,0),  ex("so_start", 1,0,0,0,0,0,0));
         apply(inp(0,0,1,3,0,0,0),  ex("so_sel",   2,0,0,20,0,0,0));
         apply(inp(0,0,0,0,1,20,0), ex("so_pay",   3,1,3,20,-1,1,0));
         apply(idle(),              ex("so_done",  0,0,0,0,0,0,0,0,0,3,3-k));
      end
      apply(inp(1,0,0,0,0,0,0), ex("so5_start", 1,0,0,0,0,0,0));
      apply(inp(0,0,1,3,0,0,0), ex("so5_sel",   0,0,0,0,0,0,0,1,0,3,0));
      apply(rs(idle(),3,3),     ex("rs_3",      0,0,0,0,0,0,0,0,0,3,3));
      apply(rs(idle(),3,15),    ex("rs_sat",    0,0,0,0,0,0,0,0,0,3,15));
      apply(rs(idle(),7,5),     ex("rs_badcode",0,0,0,0,0,0,0,0,0,4,4));

      // Asynchronous reset in PAY with credit 30: no refund pulse.
      apply(inp(1,0,0,0,0,0,0),  ex("rst_start", 1,0,0,0,0,0,0));
      apply(inp(0,0,1,1,0,0,0),  ex("rst_sel",   2,0,0,50,0,0,0));
      apply(inp(0,0,0,0,1,30,0), ex("rst_c30",   2,0,0,50,30,0,0));
      @(negedge clk);
      drive(idle());
      rst_n = 1'b0;
      #1;
      check("midrst/state",      32'(state),        32'd0);
      check("midrst/credit",     32'(credit),       32'd0);
      check("midrst/change",     32'(change_valid), 32'd0);
      check("midrst/stock_flat", 32'(stock_flat),   32'h44444);
      @(negedge clk);
      rst_n = 1'b1;
      apply(idle(), ex("rst_after", 0,0,0,0,0,0,0));

      // Restock product 2 by 2 in the DISPENSE cycle of product 2 (stock 4 -> 5).
      apply(inp(1,0,0,0,0,0,0),  ex("col_start", 1,0,0,0,0,0,0));
      apply(inp(0,0,1,2,0,0,0),  ex("col_sel",   2,0,0,35,0,0,0));
      apply(inp(0,0,0,0,1,35,0), ex("col_pay",   3,1,2,35,-1,1,0,0,0,2,4));
      apply(rs(idle(),2,2),      ex("col_done",  0,0,0,0,0,0,0,0,0,2,5));

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
